// File: rtl/mips_pkg.sv
// Shared encodings for the load/store unit: FSM states, access size codes, default timeout.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int TIMEOUT_DEFAULT = 16;

   // Halfwords need an even address, words a word-aligned one; size 11 never passes.
   function automatic logic is_legal(input logic [1:0] size, input logic [1:0] offset);
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~offset[0];
         SZ_WORD: ok = (offset == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles the pipeline request/response and data-memory signals of the load/store unit.
// Latency: n/a (wiring only).
// Backpressure: pipeline holds its request while busy is high; memory stalls via mem_ready.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        misalign;
   logic        timeout_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_write_en;
   logic        mem_read_en;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   // Load/store unit side.
   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  mem_ready, mem_rdata,
      output busy, rsp_valid, rsp_rdata, misalign, timeout_err,
      output mem_addr, mem_wdata, mem_be, mem_write_en, mem_read_en
   );

   // Pipeline plus data-memory side.
   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output mem_ready, mem_rdata,
      input  busy, rsp_valid, rsp_rdata, misalign, timeout_err,
      input  mem_addr, mem_wdata, mem_be, mem_write_en, mem_read_en
   );
endinterface

// File: rtl/lsu_align.sv
// Lane steering: store byte enables / replicated write data, and load lane extraction with extension.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
   import mips_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        sign_ext,
   input  logic        write,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_fmt
);

   logic [31:0] lane;

   // Little-endian: shift the addressed byte lane down to bit 0.
   assign lane = rdata >> {offset, 3'b000};

   // Build the store side (enables and replicated data) and the formatted load result.
   always_comb begin
      be        = 4'b0000;
      wdata_rep = wdata;
      rdata_fmt = 32'd0;
      case (size)
         SZ_BYTE: begin
            if (write) be = 4'b0001 << offset;
            wdata_rep = {4{wdata[7:0]}};
            rdata_fmt = {{24{sign_ext & lane[7]}}, lane[7:0]};
         end
         SZ_HALF: begin
            if (write) be = offset[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata_fmt = {{16{sign_ext & lane[15]}}, lane[15:0]};
         end
         SZ_WORD: begin
            if (write) be = 4'b1111;
            rdata_fmt = rdata;
         end
         default: ;
      endcase
      // Stores report zero on the response bus.
      if (write) rdata_fmt = 32'd0;
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: aligns pipeline accesses onto a word memory, with misalign and timeout aborts.
// Latency: accept in cycle N, rsp_valid in N+2 when mem_ready is high on the first ACCESS cycle.
// Backpressure: busy stalls the pipeline outside IDLE; mem_ready low extends ACCESS up to TIMEOUT cycles.
module load_store_unit
   import mips_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT + 1);

   lsu_state_t  state, state_n;
   logic [CW-1:0] cnt;
   logic        write_q, signed_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        misalign_q, timeout_q;
   logic        accept, illegal, capture, abort;
   logic [3:0]  be_w;
   logic [31:0] wdata_w, rdata_w;

   // Steering works off the latched request so memory outputs stay stable through ACCESS.
   lsu_align u_align (
      .size      (size_q),
      .offset    (addr_q[1:0]),
      .sign_ext  (signed_q),
      .write     (write_q),
      .wdata     (wdata_q),
      .rdata     (bus.mem_rdata),
      .be        (be_w),
      .wdata_rep (wdata_w),
      .rdata_fmt (rdata_w)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Next state; mem_ready wins over an expiring counter on the final ACCESS cycle.
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      illegal = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (is_legal(bus.req_size, bus.req_addr[1:0])) begin
                  accept  = 1'b1;
                  state_n = ST_ACCESS;
               end else begin
                  illegal = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            if (bus.mem_ready) begin
               capture = 1'b1;
               state_n = ST_RESP;
            end else if (cnt <= CW'(1)) begin
               abort   = 1'b1;
               state_n = ST_IDLE;
            end
         end
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Request latch, timeout counter, response data and error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         write_q    <= 1'b0;
         signed_q   <= 1'b0;
         size_q     <= SZ_BYTE;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         misalign_q <= illegal;
         timeout_q  <= abort;
         if (accept) begin
            cnt      <= CW'(TIMEOUT);
            write_q  <= bus.req_write;
            signed_q <= bus.req_signed;
            size_q   <= bus.req_size;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
         end else if (state == ST_ACCESS && !bus.mem_ready && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (capture) rdata_q <= rdata_w;
      end
   end

   assign bus.busy         = (state != ST_IDLE);
   assign bus.rsp_valid    = (state == ST_RESP);
   assign bus.rsp_rdata    = rdata_q;
   assign bus.misalign     = misalign_q;
   assign bus.timeout_err  = timeout_q;
   assign bus.mem_addr     = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata    = wdata_w;
   assign bus.mem_be       = be_w;
   assign bus.mem_read_en  = (state == ST_ACCESS) && !write_q;
   assign bus.mem_write_en = (state == ST_ACCESS) && write_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles in ACCESS waiting for mem_ready before abort.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  pipeline presents an access this cycle.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 halfword, 10 word; 11 reserved.
REQ-007 req_signed  input  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 busy  output  1  stall to pipeline, high whenever state != IDLE.
REQ-011 rsp_valid  output  1  one-cycle pulse, access complete.
REQ-012 rsp_rdata  output  32  formatted load data; 0 for stores.
REQ-013 misalign  output  1  one-cycle pulse, request rejected for alignment or reserved size.
REQ-014 timeout_err  output  1  one-cycle pulse, memory did not answer within TIMEOUT.
REQ-015 mem_addr  output  32  word address to data memory: req_addr with bits [1:0] = 00.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_be  output  4  byte enables; bit k = bits [8k+7:8k].
REQ-018 mem_write_en / mem_read_en  output  1 each  memory strobes, mutually exclusive.
REQ-019 mem_ready  input  1  memory completed the current access.
REQ-020 mem_rdata  input  32  memory word read data, valid when mem_ready = 1.

Function
REQ-021 States SHALL be IDLE, ACCESS, RESP.
REQ-022 In IDLE with req_valid = 1, the unit SHALL latch all req_* fields; aligned requests go to ACCESS.
REQ-023 Alignment rule: halfword needs addr[0] = 0; word needs addr[1:0] = 00; size 11 is always illegal.
REQ-024 Illegal requests SHALL stay in IDLE, pulse misalign the next cycle, issue no memory strobe, and assert no rsp_valid.
REQ-025 In ACCESS, mem_read_en or mem_write_en SHALL be high and mem_addr/mem_wdata/mem_be held stable until mem_ready.
REQ-026 ACCESS with mem_ready = 1 SHALL capture the formatted data and go to RESP.
REQ-027 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the unit returns to IDLE.
REQ-028 Minimum latency, with mem_ready high on the first ACCESS cycle: accept in cycle N, rsp_valid in cycle N+2.
REQ-029 A down-counter SHALL load TIMEOUT on entry to ACCESS.
REQ-030 When the counter reaches 0 without mem_ready, the unit SHALL drop the strobes, pulse timeout_err, go to IDLE, and assert no rsp_valid.
REQ-031 req_valid SHALL be ignored while busy = 1; the pipeline holds the request.
REQ-032 Byte order is little-endian: offset k = addr[1:0] maps to lane k.
REQ-033 Byte store: mem_wdata = wdata[7:0] replicated ×4, mem_be = 1 << k.
REQ-034 Halfword store: mem_wdata = wdata[15:0] replicated ×2, mem_be = 0011 (k = 0) or 1100 (k = 2).
REQ-035 Word store: mem_be = 1111; mem_be = 0000 for loads.
REQ-036 Loads SHALL extract the addressed lane(s) and extend to 32 bits per req_signed; word loads pass through.
REQ-037 rsp_rdata SHALL hold its value until the next RESP and be 0 after a store.
REQ-038 The same-cycle mem_ready and counter = 0 SHALL count as success.

Reset
REQ-039 On rst, the unit SHALL go to IDLE immediately and asynchronously.
REQ-040 On rst, busy, rsp_valid, misalign, timeout_err, mem_write_en and mem_read_en SHALL be 0.
REQ-041 On rst, rsp_rdata, mem_addr, mem_wdata and mem_be SHALL be 0, and the counter SHALL be 0.
REQ-042 Reset mid-ACCESS SHALL abort the access with no response pulse after release.

Structure
REQ-043 The shared package mips_pkg SHALL hold the state encoding, the req_size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the default TIMEOUT.
REQ-044 Lane steering and extension SHALL be one combinational sub-module lsu_align, instantiated in load_store_unit.

Verification
REQ-045 Load word: lw addr 0x10, mem_ready high immediately, mem_rdata 0x8899AABB -> mem_addr 0x10, read_en for 1 cycle, rsp_rdata 0x8899AABB two cycles after accept.
REQ-046 Signed and unsigned byte load: lb then lbu at 0x13, mem_rdata 0x80000000 -> rsp_rdata 0xFFFFFF80, then 0x00000080.
REQ-047 Halfword store: sh addr 0x22, wdata 0x1234ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, write_en high, rsp_rdata 0.
REQ-048 Misalignment: lw at 0x06 -> misalign pulse, no strobes, busy stays 0, no rsp_valid.
REQ-049 Timeout: TIMEOUT = 4, mem_ready held 0 -> strobe for 4 cycles, timeout_err pulse, back to IDLE.
REQ-050 Reset and wait states: rst asserted during ACCESS -> all outputs 0 at once; then mem_ready delayed 3 cycles -> busy high throughout, one rsp_valid.
